// File: rtl/alu_iter_pkg.sv
// ============================================================================
// alu_iter_pkg : opcodes, FSM state type and opcode classification for alu_iter
// Optional feature macro: ALU_ITER_DIV_EN (iterative unsigned divider)
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_iter_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_MULU = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ops that go through the WIDTH-cycle iterative unit.
  function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_ITER_DIV_EN
    return (op == OP_MULU) || (op == OP_DIVU);
`else
    return (op == OP_MULU);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_iter_seq.sv
// ============================================================================
// alu_iter_seq : shift-add multiplier, restoring divider and iteration counter
// Optional feature macro: ALU_ITER_DIV_EN (divider present when defined)
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_iter_seq
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             run_i,
`ifdef ALU_ITER_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] lo_next_o,
  output logic [WIDTH-1:0] hi_next_o
);

  // hi_q/lo_q: multiply = {accumulator, multiplier}, divide = {remainder, quotient}
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opb_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

`ifdef ALU_ITER_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  // Divisor 0 always "fits", yielding all-ones quotient and remainder = dividend.
  always_comb begin
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_hi    = div_ge ? WIDTH'(div_shift - {1'b0, opb_q}) : div_shift[WIDTH-1:0];
    div_lo    = {lo_q[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          div_q <= 1'b0;
    else if (start_i) div_q <= div_i;
  end

  assign hi_next_o = div_q ? div_hi : mul_hi;
  assign lo_next_o = div_q ? div_lo : mul_lo;
`else
  assign hi_next_o = mul_hi;
  assign lo_next_o = mul_lo;
`endif

  assign last_o = (cnt_q == SHW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      hi_q  <= '0;
      lo_q  <= a_i;
      opb_q <= b_i;
      cnt_q <= '0;
    end else if (run_i) begin
      hi_q  <= hi_next_o;
      lo_q  <= lo_next_o;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_iter.sv
// ============================================================================
// alu_iter : handshaked ALU with single-cycle ops and iterative MULU/DIVU
// Optional feature macro: ALU_ITER_DIV_EN (enables DIVU divider)
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             zero
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_hi_q;
  logic [WIDTH-1:0] out_hi_d;
  logic             zero_q;
  logic [WIDTH-1:0] alu_res;
  logic             seq_start;
  logic             seq_run;
  logic             seq_last;
  logic [WIDTH-1:0] seq_lo;
  logic [WIDTH-1:0] seq_hi;

  always_comb begin
    alu_res = '0;
    case (ctrl)
      OP_AND:          alu_res = in1 & in2;
      OP_OR:           alu_res = in1 | in2;
      OP_ADD, OP_ADDI: alu_res = in1 + in2;
      OP_SUB:          alu_res = in1 - in2;
      OP_SLT:          alu_res = WIDTH'($signed(in1) < $signed(in2));
      OP_SLL:          alu_res = in2 << shamt;
      OP_SRL:          alu_res = in2 >> shamt;
      OP_SRA:          alu_res = $signed(in2) >>> shamt;
      OP_NOR:          alu_res = ~(in1 | in2);
      default:         alu_res = '0;
    endcase
  end

  alu_iter_seq #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .start_i   (seq_start),
    .run_i     (seq_run),
`ifdef ALU_ITER_DIV_EN
    .div_i     (ctrl == OP_DIVU),
`endif
    .a_i       (in1),
    .b_i       (in2),
    .last_o    (seq_last),
    .lo_next_o (seq_lo),
    .hi_next_o (seq_hi)
  );

  // The final iteration's next-state is captured directly so DONE follows it with no extra cycle.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    out_hi_d  = out_hi_q;
    seq_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_iter_op(ctrl)) begin
            seq_start = 1'b1;
            state_d   = ST_CALC;
          end else begin
            out_d    = alu_res;
            out_hi_d = '0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_CALC: begin
        if (seq_last) begin
          out_d    = seq_lo;
          out_hi_d = seq_hi;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      out_hi_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      zero_q   <= (out_d == '0);
    end
  end

  assign seq_run   = (state_q == ST_CALC);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_iter.sv
// ============================================================================
// tb_alu_iter : directed vector table plus stall and reset-abort sequences
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_iter;

  localparam int W = 32;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SLL  = 4'b0011;
  localparam logic [3:0] C_ADDI = 4'b0100;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SRL  = 4'b1000;
  localparam logic [3:0] C_MULU = 4'b1001;
  localparam logic [3:0] C_DIVU = 4'b1010;
  localparam logic [3:0] C_SRA  = 4'b1011;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_ILL  = 4'b0101;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   ctrl = '0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic [4:0]   shamt = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
  logic [W-1:0] out_hi;
  logic         zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .in1       (in1),
    .in2       (in2),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_hi    (out_hi),
    .zero      (zero)
  );

  typedef struct {
    logic [3:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   sh;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           lat;
    string        nm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [4:0] sh, input logic [W-1:0] lo, input logic [W-1:0] hi,
                     input int lat, input string nm);
    vec_t v;
    v.c = c; v.a = a; v.b = b; v.sh = sh; v.lo = lo; v.hi = hi; v.lat = lat; v.nm = nm;
    vecs.push_back(v);
  endtask

  // Issue one op, measure latency from the accept edge, check result and handshake.
  task automatic run_op(input vec_t v);
    int lat;
    bit saw_ready;
    chk($sformatf("%s in_ready_before", v.nm), 64'(in_ready), 64'd1);
    ctrl = v.c; in1 = v.a; in2 = v.b; shamt = v.sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = $urandom; in2 = $urandom; shamt = 5'($urandom); ctrl = 4'($urandom);
    lat = 1;
    saw_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) saw_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s latency", v.nm), 64'(lat), 64'(v.lat));
    chk($sformatf("%s out", v.nm), 64'(out), 64'(v.lo));
    chk($sformatf("%s out_hi", v.nm), 64'(out_hi), 64'(v.hi));
    chk($sformatf("%s zero", v.nm), 64'(zero), 64'(v.lo == '0));
    if (v.lat > 1) chk($sformatf("%s in_ready_busy", v.nm), 64'(saw_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk($sformatf("%s out_valid_after", v.nm), 64'(out_valid), 64'd0);
    chk($sformatf("%s in_ready_after", v.nm), 64'(in_ready), 64'd1);
  endtask

  initial begin
    vec_t v;

    add(C_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 32'h0, 1, "add_ovf");
    add(C_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 32'h0, 1, "slt_neg");
    add(C_SLT,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 32'h0, 1, "slt_pos");
    add(C_SRA,  32'h0,        32'h80000000, 5'd4,  32'hF8000000, 32'h0, 1, "sra_neg");
    add(C_SRA,  32'h0,        32'h7FFFFFF0, 5'd4,  32'h07FFFFFF, 32'h0, 1, "sra_pos");
    add(C_SUB,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 32'h0, 1, "sub_zero");
    add(C_SUB,  32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, 32'h0, 1, "sub_wrap");
    add(C_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 32'h0, 1, "and");
    add(C_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'hFFF0FFF0, 32'h0, 1, "or");
    add(C_NOR,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h000F000F, 32'h0, 1, "nor");
    add(C_SLL,  32'h0,        32'h00000001, 5'd31, 32'h80000000, 32'h0, 1, "sll31");
    add(C_SRL,  32'h0,        32'h80000000, 5'd4,  32'h08000000, 32'h0, 1, "srl");
    add(C_ADDI, 32'hFFFFFFFF, 32'h00000002, 5'd0,  32'h00000001, 32'h0, 1, "addi_wrap");
    add(C_ILL,  32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h00000000, 32'h0, 1, "illegal");
    add(C_MULU, 32'hFFFFFFFF, 32'h00000002, 5'd0,  32'hFFFFFFFE, 32'h1, 33, "mulu_x2");
    add(C_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h00000001, 32'hFFFFFFFE, 33, "mulu_max");
`ifdef ALU_ITER_DIV_EN
    add(C_DIVU, 32'd100,      32'd7,        5'd0,  32'd14,       32'd2,   33, "divu");
    add(C_DIVU, 32'd100,      32'd0,        5'd0,  32'hFFFFFFFF, 32'd100, 33, "divu_by0");
`else
    add(C_DIVU, 32'd100,      32'd7,        5'd0,  32'd0,        32'd0,   1,  "divu_off");
    add(C_DIVU, 32'd100,      32'd0,        5'd0,  32'd0,        32'd0,   1,  "divu_off_by0");
`endif

    #12;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out", 64'(out), 64'd0);
    chk("rst out_hi", 64'(out_hi), 64'd0);
    chk("rst zero", 64'(zero), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) run_op(vecs[i]);

    // Consumer stall: result must hold and in_valid must be ignored.
    ctrl = C_ADD; in1 = 32'd3; in2 = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in1 = 32'hDEAD0000; in2 = 32'h1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d out", i), 64'(out), 64'd7);
      chk($sformatf("stall%0d out_hi", i), 64'(out_hi), 64'd0);
      chk($sformatf("stall%0d zero", i), 64'(zero), 64'd0);
      chk($sformatf("stall%0d in_ready", i), 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release out_valid", 64'(out_valid), 64'd0);
    chk("release in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("release no_accept", 64'(out_valid), 64'd0);

    // Reset mid-MULU aborts with no result.
    ctrl = C_MULU; in1 = 32'hFFFFFFFF; in2 = 32'h2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort out", 64'(out), 64'd0);
    chk("abort out_hi", 64'(out_hi), 64'd0);
    chk("abort zero", 64'(zero), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort in_ready", 64'(in_ready), 64'd1);
    chk("abort no_result", 64'(out_valid), 64'd0);
    v.c = C_ADD; v.a = 32'd2; v.b = 32'd3; v.sh = 5'd0; v.lo = 32'd5; v.hi = 32'd0;
    v.lat = 1; v.nm = "post_abort_add";
    run_op(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8..64, power of two.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 ctrl  input  4  operation code.
REQ-008 in1, in2  input  WIDTH each  operands, two's complement where signed.
REQ-009 shamt  input  SHW  shift amount.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out  output  WIDTH  primary result: low product word or quotient.
REQ-013 out_hi  output  WIDTH  high product word or remainder; 0 for all other ops.
REQ-014 zero  output  1  high when out == 0, qualified by out_valid.

Function
REQ-015 Opcodes: AND 0000, OR 0001, ADD 0010, SLL 0011, ADDI 0100 (same as ADD), SUB 0110, SLT 0111, SRL 1000, MULU 1001, DIVU 1010, SRA 1011, NOR 1100; any other code -> out 0.
REQ-016 FSM states: IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-017 Accept = in_valid && in_ready; ctrl, in1, in2 and shamt are latched at accept and ignored afterwards.
REQ-018 Single-cycle ops: IDLE -> DONE on accept; out_valid rises the cycle after accept (latency 1).
REQ-019 MULU/DIVU: IDLE -> CALC on accept; iteration counter runs WIDTH cycles; CALC -> DONE; out_valid rises WIDTH+1 cycles after accept.
REQ-020 DONE -> IDLE on out_ready; no new accept in the same cycle; peak throughput is one single-cycle op every 2 cycles.
REQ-021 While out_valid && !out_ready, out, out_hi and zero hold stable.
REQ-022 ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
REQ-023 SLT is a signed compare; result is 1 or 0, zero-extended.
REQ-024 SLL/SRL shift in2 by shamt with zero fill; SRA shifts in2 with sign fill.
REQ-025 MULU is an unsigned shift-add multiply; the 2*WIDTH product is split {out_hi, out}.
REQ-026 DIVU is an unsigned restoring divide: out = quotient, out_hi = remainder.
REQ-027 DIVU by 0: out = all ones, out_hi = in1; latency is unchanged.
REQ-028 Outputs change only on entering DONE; outside DONE, out_valid = 0 and out/out_hi keep their last values.

Reset
REQ-029 On rst: state IDLE, out_valid 0, out 0, out_hi 0, zero 1 (since out = 0), counter 0, in_ready 1 after release.
REQ-030 Reset asserted in CALC or DONE aborts the operation with no result and no residual state.

Configuration
REQ-031 Macro ALU_ITER_DIV_EN defined: DIVU is implemented per REQ-026/027.
REQ-032 ALU_ITER_DIV_EN undefined: no divider logic; DIVU is a single-cycle op returning out 0, out_hi 0.

Structure
REQ-033 Package alu_iter_pkg holds the opcode localparams (REQ-015) and the FSM state typedef.
REQ-034 Sub-module alu_iter_seq holds the shift-add multiplier, the restoring divider and the iteration counter; alu_iter holds the FSM, handshake and single-cycle datapath.

Verification (WIDTH=32)
REQ-035 ADD 0x7FFFFFFF + 0x1 -> out 0x80000000, zero 0, out_valid exactly 1 cycle after accept.
REQ-036 SLT 0xFFFFFFFF vs 0x1 -> out 1; SRA in2=0x80000000, shamt=4 -> 0xF8000000; SUB 5-5 -> out 0, zero 1.
REQ-037 MULU 0xFFFFFFFF * 0x2 -> out 0xFFFFFFFE, out_hi 0x1, out_valid 33 cycles after accept, in_ready 0 throughout.
REQ-038 DIVU 100/7 -> out 14, out_hi 2; 100/0 -> out 0xFFFFFFFF, out_hi 100; without ALU_ITER_DIV_EN -> 0/0 at latency 1.
REQ-039 out_ready held low 5 cycles in DONE -> out/out_hi/zero stable, in_ready 0, in_valid ignored.
REQ-040 rst pulsed at cycle 10 of MULU -> out_valid 0, out 0 immediately; next ADD 2+3 -> 5 normally.
